// File: rtl/sha256_wk_round_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
//   Shared definitions for the SHA-256 round-word feeder:
//     - word / index types and window geometry
//     - the 64-entry K round-constant table and a lookup helper
//     - the message-schedule small-sigma functions
//     - the feeder state enum
//     - the fixed padding words used by the double-SHA-256 build
//       (SHA256D_PAD_EN)
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int SHA_ROUNDS = 64;
    localparam int WIN_DEPTH  = 16;
    localparam int IDX_W      = 6;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Second-hash padding for a 256-bit message: the 0x80 marker byte
    // followed by the 64-bit bit length (256 = 0x100).
    localparam word_t PAD_WORD_START = 32'h8000_0000;
    localparam word_t PAD_WORD_LEN   = 32'h0000_0100;

    localparam word_t K_TABLE [SHA_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t k_const(input idx_t idx);
        return K_TABLE[idx];
    endfunction

    // sigma0(x) = rotr7 ^ rotr18 ^ shr3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = rotr17 ^ rotr19 ^ shr10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_wk_round_feeder_w_next.sv
// -----------------------------------------------------------------------------
// sha256_w_next
//   Combinational message-schedule word generator. Given the current
//   16-word window (win[0] = W_t), produces W_t+16:
//     w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0]  (mod 2^32)
//
// Ports
//   w_0   in  32  win[0]  (W_t)
//   w_1   in  32  win[1]  (W_t+1)
//   w_9   in  32  win[9]  (W_t+9)
//   w_14  in  32  win[14] (W_t+14)
//   w_new out 32  W_t+16
// -----------------------------------------------------------------------------
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [31:0] w_0,
    input  logic [31:0] w_1,
    input  logic [31:0] w_9,
    input  logic [31:0] w_14,
    output logic [31:0] w_new
);

    // 32-bit sum; the carry out of bit 31 falls off the result width.
    always_comb begin
        w_new = sigma1(w_14) + w_9 + sigma0(w_1) + w_0;
    end

endmodule

// File: rtl/sha256_wk_round_feeder.sv
// -----------------------------------------------------------------------------
// sha256_wk_round_feeder
//   Accepts one 512-bit SHA-256 message block over a valid/ready handshake,
//   expands it through a 16-word sliding schedule window and streams one
//   round word per cycle (W_t and W_t + K_t, t = 0..ROUNDS-1) to a
//   compression datapath. Outputs are registered and throttled by wk_ready.
//
//   Build option: define SHA256D_PAD_EN to hardwire the feeder for the
//   second hash of double SHA-256. Only block_in[511:256] (first digest) is
//   used; W8..W15 are replaced at load by the fixed 256-bit-message padding.
//
// Parameters
//   ROUNDS     round words per block (64 for SHA-256; 16..64 for short sims)
//
// Ports
//   CLK        in   1    clock, all state on rising edge
//   RST        in   1    synchronous active-high reset
//   blk_valid  in   1    block_in valid
//   blk_ready  out  1    feeder idle and able to take a block
//   block_in   in   512  W0 in [511:480] ... W15 in [31:0]
//   wk_valid   out  1    wk_out / w_out / round_idx valid
//   wk_ready   in   1    downstream accepts the current word
//   wk_out     out  32   W_t + K_t mod 2^32
//   w_out      out  32   W_t
//   round_idx  out  6    t
//   last       out  1    t == ROUNDS-1
// -----------------------------------------------------------------------------
module sha256_wk_round_feeder
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] block_in,
    output logic         wk_valid,
    input  logic         wk_ready,
    output logic [31:0]  wk_out,
    output logic [31:0]  w_out,
    output logic [5:0]   round_idx,
    output logic         last
);

    localparam idx_t LAST_IDX = idx_t'(ROUNDS - 1);

    state_e state_q, state_d;

    word_t  win_q [WIN_DEPTH];
    word_t  win_d [WIN_DEPTH];
    word_t  load_words [WIN_DEPTH];

    logic   wk_valid_q, wk_valid_d;
    word_t  wk_out_q,   wk_out_d;
    word_t  w_out_q,    w_out_d;
    idx_t   round_idx_q, round_idx_d;

    idx_t   next_idx;
    word_t  w_new;
    logic   load;
    logic   xfer;
    logic   is_last;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign load     = blk_valid && blk_ready;
    assign xfer     = wk_valid_q && wk_ready;
    assign is_last  = (round_idx_q == LAST_IDX);
    assign next_idx = round_idx_q + idx_t'(1);

    // -------------------------------------------------------------------------
    // Block unpacking (and optional double-SHA padding)
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < WIN_DEPTH; i++) begin
            load_words[i] = block_in[511 - 32*i -: 32];
        end
`ifdef SHA256D_PAD_EN
        load_words[8] = PAD_WORD_START;
        for (int i = 9; i < WIN_DEPTH - 1; i++) begin
            load_words[i] = '0;
        end
        load_words[WIN_DEPTH-1] = PAD_WORD_LEN;
`endif
    end

`ifdef SHA256D_PAD_EN
    // The lower half of the block carries no data in this build.
    logic pad_unused_low;
    assign pad_unused_low = ^block_in[255:0];
`endif

    // -------------------------------------------------------------------------
    // Schedule expansion: W_t+16 from the current window
    // -------------------------------------------------------------------------
    sha256_w_next u_w_next (
        .w_0   (win_q[0]),
        .w_1   (win_q[1]),
        .w_9   (win_q[9]),
        .w_14  (win_q[14]),
        .w_new (w_new)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = RUN;
            RUN:     if (xfer && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Gated by RST so no block can be accepted on the reset edge, whatever
    // state the flops hold.
    always_comb begin
        blk_ready = (state_q == IDLE) && !RST;
    end

    // -------------------------------------------------------------------------
    // Window and output-register next values
    // -------------------------------------------------------------------------
    always_comb begin
        win_d       = win_q;
        wk_valid_d  = wk_valid_q;
        w_out_d     = w_out_q;
        wk_out_d    = wk_out_q;
        round_idx_d = round_idx_q;

        if (load) begin
            win_d       = load_words;
            wk_valid_d  = 1'b1;
            round_idx_d = '0;
            w_out_d     = load_words[0];
            wk_out_d    = load_words[0] + k_const('0);
        end else if (xfer) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WIN_DEPTH-1] = w_new;

            // win_q[1] becomes the new win[0]; present it with its K now so
            // the outputs stay registered.
            w_out_d  = win_q[1];
            wk_out_d = win_q[1] + k_const(next_idx);

            if (is_last) begin
                wk_valid_d  = 1'b0;
                round_idx_d = '0;
            end else begin
                round_idx_d = next_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the window is cleared on reset (it is small, and a cleared
    // window means no word of an aborted block survives into the next one).
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
            wk_valid_q  <= 1'b0;
            w_out_q     <= '0;
            wk_out_q    <= '0;
            round_idx_q <= '0;
        end else begin
            win_q       <= win_d;
            wk_valid_q  <= wk_valid_d;
            w_out_q     <= w_out_d;
            wk_out_q    <= wk_out_d;
            round_idx_q <= round_idx_d;
        end
    end

    assign wk_valid  = wk_valid_q;
    assign wk_out    = wk_out_q;
    assign w_out     = w_out_q;
    assign round_idx = round_idx_q;
    assign last      = is_last;

endmodule

// File: tb/tb_sha256_wk_round_feeder.sv
// -----------------------------------------------------------------------------
// tb_sha256_wk_round_feeder
//   Directed bench for sha256_wk_round_feeder (default ROUNDS = 64).
//   Inputs change and outputs are sampled on the falling clock edge.
//   Expected schedule words come from an independent model in this file.
// -----------------------------------------------------------------------------
module tb_sha256_wk_round_feeder;

    logic         CLK = 1'b0;
    logic         RST;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] block_in;
    logic         wk_valid;
    logic         wk_ready;
    logic [31:0]  wk_out;
    logic [31:0]  w_out;
    logic [5:0]   round_idx;
    logic         last;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_w [64];

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_wk_round_feeder dut (
        .CLK       (CLK),
        .RST       (RST),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .block_in  (block_in),
        .wk_valid  (wk_valid),
        .wk_ready  (wk_ready),
        .wk_out    (wk_out),
        .w_out     (w_out),
        .round_idx (round_idx),
        .last      (last)
    );

    always #5 CLK = ~CLK;

    // Hard stop in case a step never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] tb_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] tb_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
`ifdef SHA256D_PAD_EN
        exp_w[8] = 32'h8000_0000;
        for (int i = 9; i < 15; i++) exp_w[i] = 32'h0;
        exp_w[15] = 32'h0000_0100;
`endif
        for (int t = 16; t < 64; t++)
            exp_w[t] = tb_s1(exp_w[t-2]) + exp_w[t-7] + tb_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // -------------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wk_valid"},  wk_valid,  32'd0);
        check({tag, "_round_idx"}, round_idx, 32'd0);
        check({tag, "_last"},      last,      32'd0);
        check({tag, "_blk_ready"}, blk_ready, 32'd1);
    endtask

    // Entered just after a falling edge while the feeder is idle.
    task automatic load_block(input logic [511:0] blk);
        block_in  = blk;
        blk_valid = 1'b1;
        #1;
        check("load_blk_ready", blk_ready, 32'd1);
        @(negedge CLK);
        blk_valid = 1'b0;
        check("load_wk_valid", wk_valid, 32'd1);
    endtask

    // Consumes rounds start..stop-1; entered and left on a falling edge with
    // the word for the current index on the outputs.
    task automatic run_stream(input int start, input int stop, input bit rnd);
        int idx = start;
        int cyc = 0;
        bit r;
        while (idx < stop && cyc < 2000) begin
            check($sformatf("valid[%0d]", idx),  wk_valid,  32'd1);
            check($sformatf("bready[%0d]", idx), blk_ready, 32'd0);
            check($sformatf("idx[%0d]", idx),    round_idx, idx);
            check($sformatf("w[%0d]", idx),      w_out,     exp_w[idx]);
            check($sformatf("wk[%0d]", idx),     wk_out,    exp_w[idx] + K_TB[idx]);
            check($sformatf("last[%0d]", idx),   last,      {31'd0, idx == 63});
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wk_ready = r;
            if (r) idx++;
            @(negedge CLK);
            cyc++;
        end
        check("stream_done", idx, stop);
        wk_ready = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [511:0] blk;
        logic [511:0] blk_b;

        RST       = 1'b1;
        blk_valid = 1'b0;
        wk_ready  = 1'b1;
        block_in  = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_wk_valid",  wk_valid,  32'd0);
        check("rst_w_out",     w_out,     32'd0);
        check("rst_wk_out",    wk_out,    32'd0);
        check("rst_round_idx", round_idx, 32'd0);
        check("rst_last",      last,      32'd0);
        check("rst_blk_ready", blk_ready, 32'd0);
        RST = 1'b0;
        #1;
        check("post_rst_blk_ready", blk_ready, 32'd1);
        @(negedge CLK);

        // "abc" padded block, wk_ready held high
        blk = '0;
        blk[511:480] = 32'h6162_6380;
        blk[31:0]    = 32'h0000_0018;
        build_model(blk);
        load_block(blk);
        check("abc_w0",  w_out,  32'h6162_6380);
        check("abc_wk0", wk_out, 32'hA3EC_9318);
        run_stream(0, 16, 1'b0);
        check("abc_w16", w_out, 32'h6162_6380);
        run_stream(16, 17, 1'b0);
`ifndef SHA256D_PAD_EN
        check("abc_w17", w_out, 32'h000F_0000);
`endif
        run_stream(17, 64, 1'b0);
        check_idle("abc_end");

        // Random block, random 50% wk_ready
        blk = rand_block();
        build_model(blk);
        load_block(blk);
        run_stream(0, 64, 1'b1);
        check_idle("rnd_end");

        // Back-to-back blocks with blk_valid held high
        blk   = rand_block();
        blk_b = rand_block();
        build_model(blk);
        load_block(blk);
        block_in  = blk_b;
        blk_valid = 1'b1;
        run_stream(0, 64, 1'b0);
        check_idle("b2b_bubble");
        @(negedge CLK);
        blk_valid = 1'b0;
        build_model(blk_b);
        run_stream(0, 64, 1'b0);
        check_idle("b2b_end");

        // Reset in the middle of a block (round 30)
        blk = rand_block();
        build_model(blk);
        load_block(blk);
        run_stream(0, 30, 1'b0);
        RST = 1'b1;
        #1;
        check("mid_rst_blk_ready_low", blk_ready, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_idle("mid_rst");
        check("mid_rst_w_out",  w_out,  32'd0);
        check("mid_rst_wk_out", wk_out, 32'd0);
        blk = rand_block();
        build_model(blk);
        load_block(blk);
        run_stream(0, 64, 1'b0);
        check_idle("post_rst_end");

        // First word held while wk_ready stays low
        wk_ready = 1'b0;
        blk = rand_block();
        build_model(blk);
        load_block(blk);
        for (int i = 0; i < 20; i++) begin
            check("hold_wk_valid",  wk_valid,  32'd1);
            check("hold_round_idx", round_idx, 32'd0);
            check("hold_w_out",     w_out,     exp_w[0]);
            check("hold_wk_out",    wk_out,    exp_w[0] + K_TB[0]);
            check("hold_blk_ready", blk_ready, 32'd0);
            @(negedge CLK);
        end
        run_stream(0, 64, 1'b1);
        check_idle("hold_end");

`ifdef SHA256D_PAD_EN
        // Second hash of SHA256d: digest of "abc" on top, junk below
        blk = {256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad,
               256'hdeadbeef_cafef00d_01234567_89abcdef_fedcba98_76543210_a5a5a5a5_5a5a5a5a};
        build_model(blk);
        load_block(blk);
        run_stream(0, 8, 1'b0);
        check("pad_w8", w_out, 32'h8000_0000);
        run_stream(8, 15, 1'b0);
        check("pad_w15", w_out, 32'h0000_0100);
        run_stream(15, 64, 1'b0);
        check_idle("pad_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
